// File: rtl/bus_arbiter_pkg.sv
// Shared types and widths for the CPU / secondary memory arbiter.
package bus_arbiter_pkg;

  localparam int AW_DEF = 20;
  localparam int DW     = 64;
  localparam int TW     = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_LOCK = 2'd2
  } state_e;

endpackage

// File: rtl/bus_arbiter_lock_timer.sv
// Saturating cycle counter bounding how long an atomic lock may be held.
module bus_arbiter_lock_timer #(
  parameter  int MAX = 16,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-ported tagged memory shared between the CPU (fixed latency, absolute
// priority) and a secondary DMA/loader port that only uses idle cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] c_ad,
  input  logic [TW-1:0] c_tag,
  input  logic          c_astb,
  input  logic          c_atomic,
  input  logic          c_rd,
  input  logic          c_wr,
  output logic [DW-1:0] c_data,
  output logic [TW-1:0] c_rtag,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [TW-1:0] d_wtag,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [TW-1:0] d_rtag,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [TW-1:0] m_wtag,
  input  logic [DW-1:0] m_rdata,
  input  logic [TW-1:0] m_rtag,
  output logic          lock_err,
  output logic          proto_err
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          atomic_q, atomic_d;
  logic          c_pend_q, c_pend_d;
  logic          d_pend_q, d_pend_d;
  logic [DW-1:0] c_data_q, c_data_d;
  logic [TW-1:0] c_rtag_q, c_rtag_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [TW-1:0] d_rtag_q, d_rtag_d;

  logic [AW-1:0] cur_addr;
  logic          cpu_acc, cpu_rd, cpu_wr;
  logic          astb_lock, lock_act, d_issue;
  logic          lock_expire, tmr_clr, tmr_en, tmr_expired;

  // A simultaneous rd+wr is treated as a write.
  assign cpu_wr    = c_wr;
  assign cpu_rd    = c_rd & ~c_wr;
  assign cpu_acc   = c_rd | c_wr;
  assign cur_addr  = c_astb ? c_ad[AW-1:0] : addr_q;
  assign astb_lock = c_astb & c_atomic & cpu_rd;
  assign lock_act  = (state_q == S_LOCK) || (state_q == S_ADDR && atomic_q);
  assign d_issue   = d_req & ~cpu_acc & ~lock_act;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    atomic_d    = atomic_q;
    lock_expire = 1'b0;
    if (c_astb) begin
      addr_d   = c_ad[AW-1:0];
      atomic_d = c_atomic;
    end
    case (state_q)
      S_IDLE: begin
        if (c_astb) state_d = astb_lock ? S_LOCK : S_ADDR;
      end
      S_ADDR: begin
        if (c_astb)                  state_d = astb_lock ? S_LOCK : S_ADDR;
        else if (cpu_rd && atomic_q) state_d = S_LOCK;
        else if (cpu_acc)            state_d = S_IDLE;
      end
      S_LOCK: begin
        // The closing write or a fresh address takes precedence over timeout.
        if (cpu_wr)           state_d = S_IDLE;
        else if (c_astb)      state_d = astb_lock ? S_LOCK : S_ADDR;
        else if (tmr_expired) begin
          state_d     = S_IDLE;
          lock_expire = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tmr_clr = (state_d == S_LOCK) && ((state_q != S_LOCK) || astb_lock);
  assign tmr_en  = (state_q == S_LOCK);

  bus_arbiter_lock_timer #(.MAX(LOCK_MAX)) u_lock_timer (
    .clk     (clk),
    .rst     (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Issue side is purely combinational so the CPU sees no added latency.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wtag  = '0;
    d_gnt   = 1'b0;
    if (!reset) begin
      if (cpu_acc) begin
        m_en    = 1'b1;
        m_we    = cpu_wr;
        m_addr  = cur_addr;
        m_wdata = c_ad;
        m_wtag  = c_tag;
      end else if (d_issue) begin
        m_en    = 1'b1;
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wtag  = d_wtag;
        d_gnt   = 1'b1;
      end
    end
  end

  assign proto_err = ~reset & c_rd & c_wr;
  assign lock_err  = ~reset & lock_expire;

  always_comb begin
    c_pend_d  = cpu_rd;
    d_pend_d  = d_gnt & ~d_we;
    c_data_d  = c_pend_q ? m_rdata : c_data_q;
    c_rtag_d  = c_pend_q ? m_rtag  : c_rtag_q;
    d_rdata_d = d_pend_q ? m_rdata : d_rdata_q;
    d_rtag_d  = d_pend_q ? m_rtag  : d_rtag_q;
  end

  // Secondary read data passes straight through on the valid cycle, then holds.
  assign c_data   = c_data_q;
  assign c_rtag   = c_rtag_q;
  assign d_rvalid = d_pend_q;
  assign d_rdata  = d_pend_q ? m_rdata : d_rdata_q;
  assign d_rtag   = d_pend_q ? m_rtag  : d_rtag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      atomic_q  <= 1'b0;
      c_pend_q  <= 1'b0;
      d_pend_q  <= 1'b0;
      c_data_q  <= '0;
      c_rtag_q  <= '0;
      d_rdata_q <= '0;
      d_rtag_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      atomic_q  <= atomic_d;
      c_pend_q  <= c_pend_d;
      d_pend_q  <= d_pend_d;
      c_data_q  <= c_data_d;
      c_rtag_q  <= c_rtag_d;
      d_rdata_q <= d_rdata_d;
      d_rtag_q  <= d_rtag_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a one-cycle-latency tagged memory model.
module tb_bus_arbiter;

  localparam int AW       = 20;
  localparam int LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   c_ad;
  logic [7:0]    c_tag;
  logic          c_astb, c_atomic, c_rd, c_wr;
  logic [63:0]   c_data;
  logic [7:0]    c_rtag;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic [7:0]    d_wtag;
  logic          d_gnt, d_rvalid;
  logic [63:0]   d_rdata;
  logic [7:0]    d_rtag;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [63:0]   m_wdata;
  logic [7:0]    m_wtag;
  logic [63:0]   m_rdata = '0;
  logic [7:0]    m_rtag  = '0;
  logic          lock_err, proto_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .c_ad(c_ad), .c_tag(c_tag), .c_astb(c_astb), .c_atomic(c_atomic),
    .c_rd(c_rd), .c_wr(c_wr), .c_data(c_data), .c_rtag(c_rtag),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wtag(d_wtag), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_rtag(d_rtag), .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wtag(m_wtag), .m_rdata(m_rdata), .m_rtag(m_rtag),
    .lock_err(lock_err), .proto_err(proto_err)
  );

  logic [71:0] mem [0:4095];

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[11:0]] <= {m_wtag, m_wdata};
      else begin
        m_rdata <= mem[m_addr[11:0]][63:0];
        m_rtag  <= mem[m_addr[11:0]][71:64];
      end
    end
  end

  task drive_idle;
    c_ad = '0; c_tag = '0; c_astb = 0; c_atomic = 0; c_rd = 0; c_wr = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wtag = '0;
  endtask

  task test_reset;
    reset = 1'b1;
    drive_idle();
    c_rd = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_en, m_we, d_gnt, d_rvalid, lock_err, proto_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {m_en, m_we, d_gnt, d_rvalid, lock_err, proto_err});
    end
    checks++;
    if ({c_data, c_rtag, d_rdata, d_rtag} !== 144'h0) begin
      failures++;
      $display("FAIL reset_data c_data=%h c_rtag=%h d_rdata=%h d_rtag=%h",
               c_data, c_rtag, d_rdata, d_rtag);
    end
    @(negedge clk);
    c_rd  = 1'b0;
    reset = 1'b0;
  endtask

  task test_plain_read;
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 20'h00123;
    d_wdata = 64'h0123456789ABCDEF; d_wtag = 8'h35;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      failures++; $display("FAIL preload_gnt got=%b want=1", d_gnt);
    end
    @(negedge clk);
    drive_idle();
    c_astb = 1; c_ad = 64'h123;
    #1;
    checks++;
    if (m_en !== 1'b0) begin
      failures++; $display("FAIL astb_only_men got=%b want=0", m_en);
    end
    @(negedge clk);
    c_astb = 0; c_ad = '0; c_rd = 1;
    #1;
    checks++;
    if ({m_en, m_we, m_addr} !== {1'b1, 1'b0, 20'h00123}) begin
      failures++;
      $display("FAIL read_issue en=%b we=%b addr=%h want 1/0/00123", m_en, m_we, m_addr);
    end
    @(negedge clk);
    c_rd = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({c_rtag, c_data} !== {8'h35, 64'h0123456789ABCDEF}) begin
      failures++;
      $display("FAIL read_data got=%h/%h want=35/0123456789abcdef", c_rtag, c_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (c_data !== 64'h0123456789ABCDEF) begin
      failures++; $display("FAIL read_hold got=%h want=0123456789abcdef", c_data);
    end
  endtask

  task test_secondary_fill;
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 20'h5; d_wdata = 64'hDEAD; d_wtag = 8'h3F;
    #1;
    checks++;
    if ({d_gnt, m_en, m_we, m_addr, m_wtag, m_wdata} !== {3'b111, 20'h5, 8'h3F, 64'hDEAD}) begin
      failures++;
      $display("FAIL fill_issue gnt=%b en=%b we=%b addr=%h tag=%h data=%h",
               d_gnt, m_en, m_we, m_addr, m_wtag, m_wdata);
    end
    @(negedge clk);
    d_req = 0; d_we = 0;
    #1;
    checks++;
    if (mem[5] !== {8'h3F, 64'hDEAD}) begin
      failures++; $display("FAIL fill_mem got=%h want=3f000000000000dead", mem[5]);
    end
    @(negedge clk);
    d_req = 1; d_addr = 20'h5;
    #1;
    checks++;
    if ({d_gnt, m_we} !== 2'b10) begin
      failures++; $display("FAIL sread_issue gnt=%b we=%b want 1/0", d_gnt, m_we);
    end
    @(negedge clk);
    d_req = 0;
    #1;
    checks++;
    if ({d_rvalid, d_rtag, d_rdata} !== {1'b1, 8'h3F, 64'hDEAD}) begin
      failures++;
      $display("FAIL sread_data vld=%b tag=%h data=%h want 1/3f/dead", d_rvalid, d_rtag, d_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b0, 64'hDEAD}) begin
      failures++; $display("FAIL sread_hold vld=%b data=%h want 0/dead", d_rvalid, d_rdata);
    end
  endtask

  task test_priority;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_req = 1; d_we = 0; d_addr = 20'h7;
      c_rd  = (i < 4);
      #1;
      checks++;
      if (d_gnt !== (i == 4)) begin
        failures++; $display("FAIL priority_gnt cycle=%0d got=%b want=%b", i, d_gnt, i == 4);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task test_atomic;
    @(negedge clk);
    c_astb = 1; c_atomic = 1; c_ad = 64'h40;
    @(negedge clk);
    c_astb = 0; c_atomic = 0; c_ad = '0; c_rd = 1;
    d_req = 1; d_we = 0; d_addr = 20'h41;
    #1;
    checks++;
    if (d_gnt !== 1'b0) begin
      failures++; $display("FAIL atomic_rd_gnt got=%b want=0", d_gnt);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c_rd = 0;
      #1;
      checks++;
      if (d_gnt !== 1'b0) begin
        failures++; $display("FAIL atomic_lock_gnt idle=%0d got=%b want=0", i, d_gnt);
      end
    end
    @(negedge clk);
    c_wr = 1; c_ad = 64'hCAFEF00D12345678; c_tag = 8'h5A;
    #1;
    checks++;
    if ({m_en, m_we, m_addr, d_gnt} !== {2'b11, 20'h40, 1'b0}) begin
      failures++;
      $display("FAIL atomic_wr en=%b we=%b addr=%h gnt=%b want 1/1/00040/0", m_en, m_we, m_addr, d_gnt);
    end
    @(negedge clk);
    c_wr = 0; c_ad = '0; c_tag = '0;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      failures++; $display("FAIL atomic_release_gnt got=%b want=1", d_gnt);
    end
    checks++;
    if (mem[12'h40] !== {8'h5A, 64'hCAFEF00D12345678}) begin
      failures++; $display("FAIL atomic_mem got=%h want=5acafef00d12345678", mem[12'h40]);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task test_lock_timeout;
    @(negedge clk);
    c_astb = 1; c_atomic = 1; c_ad = 64'h50;
    @(negedge clk);
    c_astb = 0; c_atomic = 0; c_ad = '0; c_rd = 1;
    for (int k = 0; k < LOCK_MAX; k++) begin
      @(negedge clk);
      c_rd = 0; d_req = 1; d_we = 0; d_addr = 20'h41;
      #1;
      checks++;
      if ({lock_err, d_gnt} !== 2'b00) begin
        failures++; $display("FAIL lock_hold k=%0d err=%b gnt=%b want 0/0", k, lock_err, d_gnt);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({lock_err, d_gnt} !== 2'b10) begin
      failures++; $display("FAIL lock_expire err=%b gnt=%b want 1/0", lock_err, d_gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({lock_err, d_gnt} !== 2'b01) begin
      failures++; $display("FAIL lock_after err=%b gnt=%b want 0/1", lock_err, d_gnt);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task test_proto_err;
    @(negedge clk);
    c_astb = 1; c_rd = 1; c_wr = 1; c_ad = 64'h77; c_tag = 8'h11;
    #1;
    checks++;
    if ({proto_err, m_en, m_we, m_addr, m_wdata} !== {3'b111, 20'h77, 64'h77}) begin
      failures++;
      $display("FAIL proto_issue err=%b en=%b we=%b addr=%h data=%h",
               proto_err, m_en, m_we, m_addr, m_wdata);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({proto_err, mem[12'h77]} !== {1'b0, 8'h11, 64'h77}) begin
      failures++; $display("FAIL proto_after err=%b mem=%h want 0/110..077", proto_err, mem[12'h77]);
    end
  endtask

  task test_reset_lock;
    @(negedge clk);
    c_astb = 1; c_atomic = 1; c_ad = 64'h60;
    @(negedge clk);
    c_astb = 0; c_atomic = 0; c_ad = '0; c_rd = 1;
    @(negedge clk);
    c_rd = 0; d_req = 1; d_we = 0; d_addr = 20'h5;
    #1;
    checks++;
    if (d_gnt !== 1'b0) begin
      failures++; $display("FAIL rl_locked_gnt got=%b want=0", d_gnt);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({m_en, m_we, d_gnt, d_rvalid, lock_err, proto_err, c_data, c_rtag, d_rdata, d_rtag}
        !== 150'h0) begin
      failures++;
      $display("FAIL rl_outputs en=%b we=%b gnt=%b vld=%b cdata=%h ctag=%h ddata=%h dtag=%h",
               m_en, m_we, d_gnt, d_rvalid, c_data, c_rtag, d_rdata, d_rtag);
    end
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if ({d_gnt, d_rvalid} !== 2'b10) begin
      failures++; $display("FAIL rl_idle_gnt gnt=%b vld=%b want 1/0", d_gnt, d_rvalid);
    end
    // Reset lands between the grant and the read-data cycle.
    #2 reset = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({d_rvalid, d_rdata, d_rtag} !== 73'h0) begin
      failures++;
      $display("FAIL rl_rvalid_suppress vld=%b data=%h tag=%h want 0/0/0", d_rvalid, d_rdata, d_rtag);
    end
    drive_idle();
    reset = 0;
    @(negedge clk);
    #1;
    checks++;
    if (d_rvalid !== 1'b0) begin
      failures++; $display("FAIL rl_rvalid_late got=%b want=0", d_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_plain_read();
    test_secondary_fill();
    test_priority();
    test_atomic();
    test_lock_timeout();
    test_proto_err();
    test_reset_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares a single synchronous tagged memory (64-bit data + 8-bit tag, 20-bit word address) between the CPU external bus and a secondary DMA/loader port. The CPU port has absolute priority with fixed latency because the CPU has no wait input. The secondary port is served only in idle memory cycles and is locked out during CPU read-modify-write (atomic) sequences. The block sits between `cpu` and the memory model in system benches and in the FPGA top.

## Interface
Parameters:
- AW, 20, memory word-address width
- LOCK_MAX, 16, max cycles an atomic lock may be held before forced release

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- c_ad  input  64  CPU address/data: address on [AW-1:0] when c_astb=1, write data when c_wr=1
- c_tag  input  8  CPU write tag
- c_astb  input  1  CPU address strobe
- c_atomic  input  1  read-modify-write flag, sampled with c_astb
- c_rd  input  1  CPU read
- c_wr  input  1  CPU write
- c_data  output  64  read data to CPU
- c_rtag  output  8  read tag to CPU
- d_req  input  1  secondary request, held until granted
- d_we  input  1  secondary write
- d_addr  input  AW  secondary address
- d_wdata  input  64  secondary write data
- d_wtag  input  8  secondary write tag
- d_gnt  output  1  one-cycle pulse: secondary access issued this cycle
- d_rvalid  output  1  one-cycle pulse: d_rdata/d_rtag valid
- d_rdata  output  64  secondary read data
- d_rtag  output  8  secondary read tag
- m_en, m_we  output  1 each  memory enable and write enable
- m_addr  output  AW  memory address
- m_wdata  output  64  memory write data
- m_wtag  output  8  memory write tag
- m_rdata  input  64  memory read data, valid one cycle after m_en & !m_we
- m_rtag  input  8  memory read tag, same timing
- lock_err  output  1  one-cycle pulse: lock timed out
- proto_err  output  1  one-cycle pulse: c_rd and c_wr asserted together

## Operation
- addr_q is loaded from c_ad[AW-1:0] on c_astb. The current CPU address is c_ad when c_astb=1, otherwise addr_q (bypass).
- CPU access: any cycle with c_rd|c_wr drives m_en=1, m_addr=current CPU address, and m_we=c_wr. On a write, m_wdata=c_ad and m_wtag=c_tag. If c_rd and c_wr are both asserted, the write wins and proto_err pulses.
- Repeated c_rd/c_wr without a new c_astb reuse addr_q.
- Secondary access is issued when d_req=1, c_rd=0, c_wr=0, and lock is inactive. It drives m_addr=d_addr, m_we=d_we, and data/tag, and pulses d_gnt.
- State machine:
  - S_IDLE to S_ADDR on c_astb; atomic_q=c_atomic.
  - S_ADDR: c_rd with atomic_q goes to S_LOCK. Any other c_rd/c_wr goes to S_IDLE. A new c_astb reloads and stays in S_ADDR.
  - S_LOCK: c_wr goes to S_IDLE (lock released after this write). Timer reaching LOCK_MAX goes to S_IDLE with a lock_err pulse. c_rd stays in S_LOCK. c_astb goes to S_ADDR.
  - A c_astb with atomic and c_rd in the same cycle goes directly to S_LOCK.
- Lock is active in S_LOCK and in S_ADDR with atomic_q=1.
- Lock timer: cleared on entry to S_LOCK, increments each S_LOCK cycle, saturates (no wrap).

## Timing
- CPU read issued at cycle R: m_rdata is sampled at R+1 into the c_data/c_rtag registers. c_data is valid from R+2 and held until the next CPU read capture.
- Secondary read granted at cycle G: d_rvalid pulses at G+1 with d_rdata=m_rdata (registered pass-through, held afterwards).
- Memory outputs are combinational from the inputs and state. No added latency on the issue side.
- Reset:
  - State S_IDLE, addr_q=0, atomic_q=0, timer=0.
  - c_data, c_rtag, d_rdata, d_rtag = 0.
  - d_gnt, d_rvalid, lock_err, proto_err, m_en, m_we = 0.
  - A pending d_rvalid is suppressed if reset hits between G and G+1.
- d_req held with continuous CPU traffic is starved indefinitely. This is by design.

## Structure
- Package bus_arbiter_pkg: state enum {S_IDLE, S_ADDR, S_LOCK}, default AW, word width 64, tag width 8.
- Sub-module bus_arbiter_lock_timer: a saturating counter with clear and enable inputs and an expiry output.

## Test plan
- Plain read: astb addr=0x00123, rd 1 cycle later, memory holds 0x0123456789ABCDEF/tag 0x35 -> c_data/c_rtag equal those values 2 cycles after rd.
- Secondary fill: d_req write addr=5, data=0xDEAD, tag=0x3F with CPU idle -> d_gnt same cycle, m_we=1. A later secondary read of addr 5 -> d_rvalid next cycle with 0xDEAD/0x3F.
- Priority: d_req held while the CPU issues rd on cycles 0–3 -> d_gnt first pulses at cycle 4.
- Atomic: astb atomic=1, rd, 5 idle cycles, wr -> d_req is not granted until the cycle after wr, and memory at addr_q holds the CPU data.
- Lock timeout: atomic rd with no wr -> lock_err pulses after LOCK_MAX=16 cycles and the pending d_req is granted on the next cycle.
- Errors/reset: c_rd=c_wr=1 -> proto_err pulse and a write performed. Reset asserted in S_LOCK -> S_IDLE, all outputs 0, and no d_rvalid.
